// File: rtl/data_memory_sync.sv
// data_memory_sync: synchronous byte/half/word data memory with wait states, range/alignment checks and a clear sweep after reset
module data_memory_sync #(
  parameter int DEPTH          = 256,
  parameter int WAIT_STATES    = 0,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_ld_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  typedef enum logic [1:0] {CLEAR, IDLE, WAIT} state_t;
  state_t        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          we_q, uns_q, done_q, err_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          acc, exec, x_we, x_uns, x_err;
  logic [1:0]    x_size;
  logic [31:0]   x_addr, x_wdata, word, wsrc, wd_d, rdata_d;
  logic [3:0]    be;
  logic [AW-1:0] idx;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  assign ready_o = state_q == IDLE;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;
  // With no wait states the access uses the live request; otherwise the latched copy.
  always_comb begin
    acc     = ready_o && req_i;
    exec    = (acc && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == CW'(1));
    x_we    = state_q == WAIT ? we_q : we_i;
    x_uns   = state_q == WAIT ? uns_q : unsigned_ld_i;
    x_size  = state_q == WAIT ? size_q : size_i;
    x_addr  = state_q == WAIT ? addr_q : addr_i;
    x_wdata = state_q == WAIT ? wdata_q : wdata_i;
    idx     = x_addr[AW+1:2];
    x_err   = x_size == 2'b11 || (x_size == 2'b01 && x_addr[0]) ||
              (x_size == 2'b10 && x_addr[1:0] != 2'b00) || x_addr[31:2] >= 30'(DEPTH);
    word    = mem_q[idx];
    be      = x_size == 2'b00 ? 4'b0001 << x_addr[1:0] :
              x_size == 2'b01 ? (x_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wsrc    = x_size == 2'b00 ? {4{x_wdata[7:0]}} :
              x_size == 2'b01 ? {2{x_wdata[15:0]}} : x_wdata;
    wd_d    = word;
    for (int i = 0; i < 4; i++) wd_d[8*i +: 8] = be[i] ? wsrc[8*i +: 8] : word[8*i +: 8];
    byte_v  = word[{x_addr[1:0], 3'b000} +: 8];
    half_v  = x_addr[1] ? word[31:16] : word[15:0];
    rdata_d = x_size == 2'b00 ? {{24{~x_uns & byte_v[7]}}, byte_v} :
              x_size == 2'b01 ? {{16{~x_uns & half_v[15]}}, half_v} : word;
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= exec;
      err_q  <= exec && x_err;
      if (exec && !x_err && !x_we) rdata_q <= rdata_d;
      if (exec && !x_err && x_we) mem_q[idx] <= wd_d;
      if (acc) begin
        we_q    <= we_i;
        uns_q   <= unsigned_ld_i;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      case (state_q)
        CLEAR: begin
          mem_q[ptr_q] <= '0;
          ptr_q        <= ptr_q + 1'b1;
          if (ptr_q == AW'(DEPTH - 1)) state_q <= IDLE;
        end
        IDLE: if (acc && WAIT_STATES != 0) begin
          state_q <= WAIT;
          cnt_q   <= CW'(WAIT_STATES);
        end
        WAIT: if (cnt_q == CW'(1)) state_q <= IDLE; else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_sync.sv
// tb_data_memory_sync: directed table-driven checks of a zero-wait and a three-wait memory instance
module tb_data_memory_sync;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, req0 = 1'b0, req3 = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic rdy0, dn0, er0, rdy3, dn3, er3;
  logic [31:0] rd0, rd3;
  int total = 0, bad = 0;
  data_memory_sync #(.DEPTH(16), .WAIT_STATES(0), .CLEAR_ON_RESET(1)) u0 (
    .clock_i(clk), .reset_i(rst), .req_i(req0), .we_i(we), .size_i(size), .unsigned_ld_i(uns),
    .addr_i(addr), .wdata_i(wdata), .ready_o(rdy0), .done_o(dn0), .err_o(er0), .rdata_o(rd0));
  data_memory_sync #(.DEPTH(16), .WAIT_STATES(3), .CLEAR_ON_RESET(1)) u3 (
    .clock_i(clk), .reset_i(rst), .req_i(req3), .we_i(we), .size_i(size), .unsigned_ld_i(uns),
    .addr_i(addr), .wdata_i(wdata), .ready_o(rdy3), .done_o(dn3), .err_o(er3), .rdata_o(rd3));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic        u;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [31:0] r;
  } vec_t;
  vec_t v [24];
  initial begin
    v[0]  = '{0, 2, 0, 32'h3C, 32'h0, 0, 32'h0};
    v[1]  = '{1, 2, 0, 32'h10, 32'h80FF7F01, 0, 32'h0};
    v[2]  = '{0, 0, 0, 32'h10, 32'h0, 0, 32'h00000001};
    v[3]  = '{0, 0, 0, 32'h11, 32'h0, 0, 32'h0000007F};
    v[4]  = '{0, 0, 0, 32'h12, 32'h0, 0, 32'hFFFFFFFF};
    v[5]  = '{0, 0, 0, 32'h13, 32'h0, 0, 32'hFFFFFF80};
    v[6]  = '{0, 0, 1, 32'h13, 32'h0, 0, 32'h00000080};
    v[7]  = '{1, 2, 0, 32'h14, 32'h11223344, 0, 32'h00000080};
    v[8]  = '{1, 0, 0, 32'h15, 32'h000000AA, 0, 32'h00000080};
    v[9]  = '{0, 2, 0, 32'h14, 32'h0, 0, 32'h1122AA44};
    v[10] = '{0, 1, 0, 32'h16, 32'h0, 0, 32'h00001122};
    v[11] = '{0, 1, 0, 32'h11, 32'h0, 1, 32'h00001122};
    v[12] = '{0, 2, 0, 32'h12, 32'h0, 1, 32'h00001122};
    v[13] = '{0, 3, 0, 32'h00, 32'h0, 1, 32'h00001122};
    v[14] = '{0, 2, 0, 32'h40, 32'h0, 1, 32'h00001122};
    v[15] = '{1, 2, 0, 32'h40, 32'hFFFFFFFF, 1, 32'h00001122};
    v[16] = '{0, 2, 0, 32'h10, 32'h0, 0, 32'h80FF7F01};
    v[17] = '{0, 2, 0, 32'h00, 32'h0, 0, 32'h0};
    v[18] = '{0, 1, 1, 32'h12, 32'h0, 0, 32'h000080FF};
    v[19] = '{1, 1, 0, 32'h12, 32'h1234BEEF, 0, 32'h000080FF};
    v[20] = '{0, 2, 0, 32'h10, 32'h0, 0, 32'hBEEF7F01};
    v[21] = '{0, 1, 0, 32'h12, 32'h0, 0, 32'hFFFFBEEF};
    v[22] = '{0, 0, 1, 32'h14, 32'h0, 0, 32'h00000044};
    v[23] = '{0, 2, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h00000044};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rdy0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_err", er0, 0);
    chk("rst_rdata", rd0, 0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      chk("sweep_ready0", rdy0, 32'(i == 16));
      chk("sweep_ready3", rdy3, 32'(i == 16));
    end
    for (int i = 0; i < 24; i++) begin
      we = v[i].w; size = v[i].s; uns = v[i].u; addr = v[i].a; wdata = v[i].d; req0 = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done", i), dn0, 1);
      chk($sformatf("v%0d_err", i), er0, 32'(v[i].e));
      chk($sformatf("v%0d_rdata", i), rd0, v[i].r);
      chk($sformatf("v%0d_ready", i), rdy0, 1);
    end
    req0 = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done0", dn0, 0);
    we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h20; wdata = 32'hCAFEF00D; req3 = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w3_ready_t%0d", k + 1), rdy3, 0);
      chk($sformatf("w3_done_t%0d", k + 1), dn3, 0);
      @(posedge clk);
      #1;
    end
    chk("w3_st_done", dn3, 1);
    chk("w3_st_ready", rdy3, 1);
    chk("w3_st_err", er3, 0);
    @(posedge clk);
    #1;
    req3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w3_ld_wait%0d", k), dn3, 0);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    chk("w3_ld_done", dn3, 1);
    chk("w3_ld_err", er3, 0);
    chk("w3_ld_rdata", rd3, 32'hCAFEF00D);
    we = 1'b1; addr = 32'h08; wdata = 32'hDEADBEEF; req3 = 1'b1;
    @(posedge clk);
    #1;
    req3 = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_done", dn3, 0);
    chk("mid_rst_rdata", rd3, 0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      chk("resweep_done", dn3, 0);
      chk("resweep_ready", rdy3, 32'(i == 16));
    end
    we = 1'b0; size = 2'b10; addr = 32'h20; req3 = 1'b1;
    @(posedge clk);
    #1;
    addr = 32'h08;
    repeat (3) @(posedge clk);
    #1;
    chk("resweep_20_done", dn3, 1);
    chk("resweep_20_rdata", rd3, 0);
    @(posedge clk);
    #1;
    req3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("resweep_08_done", dn3, 1);
    chk("resweep_08_rdata", rd3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
